// File: rtl/i2s_mic_rx.sv
// i2s_mic_rx -- I2S master-receiver for a 24-bit MEMS microphone.
//
// Generates sck/ws from clk, deserialises sd MSB-first with the I2S one-bit
// delay, and presents each completed word on a valid/ready port.
//
// Ports:
//   clk, reset_n      system clock, async active-low reset
//   sck, ws, lr       I2S bit clock, word select (0=left), mic channel select (0)
//   sd                serial data from mic (may be X/Z outside data bits)
//   out_data          captured sample, MSB = first bit received
//   out_right         slot of out_data (0=left, 1=right)
//   out_valid/ready   output handshake
//   overrun           sticky: a word was overwritten before being accepted
//
// Build option: I2S_MIC_RX_STEREO_EN -- capture both slots; when undefined
// only the left slot produces words and out_right is tied to 0.
module i2s_mic_rx #(
  parameter int SCK_HALF = 8,
  parameter int DATA_W   = 24
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic              sck,
  output logic              ws,
  output logic              lr,
  input  logic              sd,
  output logic [DATA_W-1:0] out_data,
  output logic              out_right,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              overrun
);

  localparam int         CW   = $clog2(SCK_HALF);
  localparam logic [4:0] LAST = 5'(DATA_W);

  logic [CW-1:0]     div_cnt;
  logic [5:0]        bit_cnt;
  logic [DATA_W-1:0] shreg;

  logic              tc, rise, fall, slot_en, cap, done, hs;
  logic [4:0]        p;
  logic [DATA_W-1:0] word;

  assign lr   = 1'b0;
  assign ws   = bit_cnt[5];
  assign p    = bit_cnt[4:0];

  assign tc   = (div_cnt == CW'(SCK_HALF - 1));
  assign rise = tc & ~sck;
  assign fall = tc &  sck;

`ifdef I2S_MIC_RX_STEREO_EN
  assign slot_en = 1'b1;
`else
  assign slot_en = ~bit_cnt[5];
`endif

  // p=0 is the I2S delay bit; data occupies p=1..DATA_W, the rest is don't-care
  assign cap  = rise & slot_en & (p != 5'd0) & (p <= LAST);
  assign done = cap & (p == LAST);
  assign word = DATA_W'({shreg, sd});
  assign hs   = out_valid & out_ready;

  // divider + sck
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= '0;
      sck     <= 1'b0;
    end else if (tc) begin
      div_cnt <= '0;
      sck     <= ~sck;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // frame position; reset at 63 so the first fall starts a frame (ws 1->0)
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  bit_cnt <= 6'd63;
    else if (fall) bit_cnt <= bit_cnt + 6'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) shreg <= '0;
    else if (cap) shreg <= word;
  end

  // Output register: a completing word always loads; it only counts as an
  // overrun if the pending word is not being taken in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else if (done) begin
      out_data  <= word;
      out_valid <= 1'b1;
      if (out_valid & ~out_ready) overrun <= 1'b1;
    end else if (hs) begin
      out_valid <= 1'b0;
    end
  end

`ifdef I2S_MIC_RX_STEREO_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  out_right <= 1'b0;
    else if (done) out_right <= bit_cnt[5];
  end
`else
  assign out_right = 1'b0;
`endif

endmodule

// File: tb/tb_i2s_mic_rx.sv
// Bench for i2s_mic_rx: a microphone model drives sd from per-frame word
// tables, directed steps check word timing/content, backpressure, the
// simultaneous complete+accept case and reset in the middle of a word.
module tb_i2s_mic_rx;
  localparam int SH = 4;
  localparam int DW = 24;
`ifdef I2S_MIC_RX_STEREO_EN
  localparam bit STEREO = 1'b1;
`else
  localparam bit STEREO = 1'b0;
`endif

  logic          clk = 1'b0, reset_n = 1'b0, sd = 1'bz, out_ready = 1'b1;
  logic          sck, ws, lr, out_right, out_valid, overrun;
  logic [DW-1:0] out_data;

  always #5 clk = ~clk;

  i2s_mic_rx #(.SCK_HALF(SH), .DATA_W(DW)) dut (
    .clk(clk), .reset_n(reset_n), .sck(sck), .ws(ws), .lr(lr), .sd(sd),
    .out_data(out_data), .out_right(out_right), .out_valid(out_valid),
    .out_ready(out_ready), .overrun(overrun)
  );

  logic [DW-1:0] lw[16], rw[16];
  int checks = 0, errors = 0;

  // Mic model: count sck falls since reset; position in frame and slot follow
  // from that count. Data bit for slot position p (1..DW) is word[DW-p].
  int fcnt = 0, gfr = -1, pos_now = 63;
  bit sck_q = 1'b0, rise_now = 1'b0, fall_now = 1'b0;

  always @(negedge clk) begin
    logic [DW-1:0] w;
    int p;
    if (!reset_n) begin
      fcnt = 0; pos_now = 63; sck_q = 1'b0;
      rise_now = 1'b0; fall_now = 1'b0; sd = 1'bz;
    end else begin
      rise_now = sck && !sck_q;
      fall_now = !sck && sck_q;
      if (fall_now) begin
        fcnt++;
        pos_now = (fcnt - 1) % 64;
        if (pos_now == 0) gfr++;
        p = pos_now % 32;
        w = (pos_now < 32) ? lw[gfr] : rw[gfr];
        if (p >= 1 && p <= DW) sd = w[DW-p];
        else                   sd = ($urandom_range(1) == 0) ? 1'bx : 1'bz;
      end
      sck_q = sck;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] exp_word(input int f, input int s);
    return (s != 0) ? rw[f] : lw[f];
  endfunction

  task automatic nxt(input int f, input int s, output int nf, output int ns);
    if (STEREO && s == 0) begin nf = f; ns = 1; end
    else begin nf = f + 1; ns = 0; end
  endtask

  // returns at the first sample after the rise that carries the last bit
  task automatic wait_done(input int f, input int s, output bit ok, output bit seen);
    ok = 1'b0; seen = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clk); #1;
      if (rise_now && gfr == f && pos_now == s*32 + DW) ok = 1'b1;
      else if (out_valid) seen = 1'b1;
    end
  endtask

  task automatic wait_fall(input int f, input int pos, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clk); #1;
      if (fall_now && gfr == f && pos_now == pos) ok = 1'b1;
    end
  endtask

  // one slot with out_ready=1: single pulse with the right word, nothing else
  task automatic do_slot(input int f, input int s);
    bit ok, seen;
    wait_done(f, s, ok, seen);
    chk("slot_timeout", 32'(ok), 32'd1);
    chk("spurious_valid", 32'(seen), 32'd0);
    if (STEREO || s == 0) begin
      chk("word_valid", 32'(out_valid), 32'd1);
      chk("word_data", 32'(out_data), 32'(exp_word(f, s)));
      chk("word_right", 32'(out_right), 32'(s));
      @(negedge clk); #1;
      chk("pulse_end", 32'(out_valid), 32'd0);
    end else begin
      chk("mono_right_ignored", 32'(out_valid), 32'd0);
    end
  endtask

  initial begin
    int n, nr, cf, cs, df, ds, af, as_, bf, bs, rf;
    bit ok, seen;
    for (int i = 0; i < 16; i++) begin
      lw[i] = DW'($urandom);
      rw[i] = DW'($urandom);
    end
    lw[0] = 24'h7FFFFF; lw[1] = 24'h800000; lw[2] = 24'hFFFFFC;
    lw[3] = 24'h123456; rw[3] = 24'hABCDEF;

    // reset state
    reset_n = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    chk("rst_sck", 32'(sck), 32'd0);
    chk("rst_ws", 32'(ws), 32'd1);
    chk("rst_lr", 32'(lr), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    reset_n = 1'b1;
    n = 0; nr = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      n++;
      if (sck && nr == 0) nr = n;
      if (!ws) break;
    end
    chk("first_rise", 32'(nr), 32'(SH));
    chk("first_ws_fall", 32'(n), 32'(2*SH));

    // plain words, consumer always ready
    for (int f = 0; f < 4; f++) begin
      do_slot(f, 0);
      do_slot(f, 1);
    end

    // completion and acceptance in the same cycle
    cf = 4; cs = 0;
    nxt(cf, cs, df, ds);
    out_ready = 1'b0;
    wait_done(cf, cs, ok, seen);
    chk("sim_c_timeout", 32'(ok), 32'd1);
    chk("sim_c_valid", 32'(out_valid), 32'd1);
    chk("sim_c_data", 32'(out_data), 32'(exp_word(cf, cs)));
    wait_fall(df, ds*32 + DW, ok);
    chk("sim_fall_timeout", 32'(ok), 32'd1);
    repeat (SH-1) @(negedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk); #1;
    chk("sim_rise_seen", 32'(rise_now), 32'd1);
    chk("sim_d_valid", 32'(out_valid), 32'd1);
    chk("sim_d_data", 32'(out_data), 32'(exp_word(df, ds)));
    chk("sim_d_right", 32'(out_right), 32'(ds));
    chk("sim_no_overrun", 32'(overrun), 32'd0);
    @(negedge clk); #1;
    chk("sim_d_taken", 32'(out_valid), 32'd0);

    // backpressure across two produced words
    out_ready = 1'b0;
    nxt(df, ds, af, as_);
    nxt(af, as_, bf, bs);
    wait_done(af, as_, ok, seen);
    chk("bp_a_timeout", 32'(ok), 32'd1);
    chk("bp_a_valid", 32'(out_valid), 32'd1);
    chk("bp_a_data", 32'(out_data), 32'(exp_word(af, as_)));
    chk("bp_a_overrun", 32'(overrun), 32'd0);
    wait_done(bf, bs, ok, seen);
    chk("bp_b_timeout", 32'(ok), 32'd1);
    chk("bp_b_valid", 32'(out_valid), 32'd1);
    chk("bp_b_data", 32'(out_data), 32'(exp_word(bf, bs)));
    chk("bp_b_right", 32'(out_right), 32'(bs));
    chk("bp_b_overrun", 32'(overrun), 32'd1);
    out_ready = 1'b1;
    @(negedge clk); #1;
    chk("bp_drain_valid", 32'(out_valid), 32'd0);
    chk("bp_sticky_overrun", 32'(overrun), 32'd1);

    // reset in the middle of a left word
    rf = bf + 1;
    wait_fall(rf, 12, ok);
    chk("mid_fall_timeout", 32'(ok), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_overrun", 32'(overrun), 32'd0);
    chk("mid_rst_ws", 32'(ws), 32'd1);
    chk("mid_rst_sck", 32'(sck), 32'd0);
    repeat (2) @(negedge clk);
    #1 reset_n = 1'b1;
    do_slot(rf + 1, 0);
    do_slot(rf + 1, 1);
    chk("end_overrun", 32'(overrun), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
